// File: rtl/seq_arith_pkg.sv
// Shared types and sizing for the sequential multiply/divide units.
// Holds the common FSM encoding and counter sizing helper.
package seq_arith_pkg;

  localparam int N_DEF = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on the packed {P,Q} register.
// P is N+1 bits wide, Q is N bits wide.
module div_restore_step #(
  parameter int N = 6
) (
  input  logic [2*N:0]  pq,
  input  logic [N-1:0]  divisor,
  output logic [2*N:0]  pq_n
);

  logic [2*N:0] sh;
  logic [N:0]   t;

  always_comb begin
    sh   = pq << 1;
    t    = sh[2*N:N] - {1'b0, divisor};
    pq_n = sh;
    if (!t[N]) begin
      pq_n[2*N:N] = t;
      pq_n[0]     = 1'b1;
    end
  end

endmodule

// File: rtl/unsigned_seq_div_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Start/Run/Done handshake with divide-by-zero and overflow status.
module unsigned_seq_div_restoring
  import seq_arith_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           run,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = cnt_w(N);

  state_t         state;
  logic [2*N:0]   pq;
  logic [2*N:0]   pq_n;
  logic [N-1:0]   dv;
  logic [CW-1:0]  cnt;
  logic           pend_dz;
  logic           pend_ov;
  logic           dz;
  logic           ov;

  div_restore_step #(.N(N)) u_step (
    .pq      (pq),
    .divisor (dv),
    .pq_n    (pq_n)
  );

  always_comb begin
    dz = (divisor == '0);
    ov = !dz && (dividend[2*N-1:N] >= divisor);
  end

  // Error cases park one cycle in DIVIDE with run low so their results
  // land one edge after acceptance, like a one-step operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pq          <= '0;
      dv          <= '0;
      cnt         <= '0;
      pend_dz     <= 1'b0;
      pend_ov     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      run         <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dv      <= divisor;
            pq      <= {1'b0, dividend};
            cnt     <= CW'(N);
            pend_dz <= dz;
            pend_ov <= ov;
            run     <= !(dz || ov);
            state   <= DIVIDE;
          end else begin
            state <= IDLE;
          end
        end
        DIVIDE: begin
          if (pend_dz || pend_ov) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= pend_dz;
            overflow    <= pend_ov;
          end else begin
            pq  <= pq_n;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state       <= DONE;
              run         <= 1'b0;
              done        <= 1'b1;
              quotient    <= pq_n[N-1:0];
              remainder   <= pq_n[2*N-1:N];
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_seq_div_restoring.sv
// Directed bench for unsigned_seq_div_restoring at N=6.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_unsigned_seq_div_restoring;

  localparam int N = 6;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           run;
  logic           done;
  logic           div_by_zero;
  logic           overflow;

  int n_cmp;
  int n_bad;
  int lat;
  int runs;
  int dones;

  unsigned_seq_div_restoring #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .run         (run),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then wait (bounded) for done.
  // lat = edges after acceptance; runs = sampled cycles with run high.
  task automatic do_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    runs  = 0;
    while (!done && lat < 20) begin
      if (run) runs++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_q",   quotient,    0);
    chk("rst_r",   remainder,   0);
    chk("rst_run", run,         0);
    chk("rst_done", done,       0);
    chk("rst_dz",  div_by_zero, 0);
    chk("rst_ov",  overflow,    0);
    rst_n = 1'b1;
    @(negedge clk);

    // exact product
    do_op(12'd1089, 6'd33);
    chk("exact_lat",  lat,       6);
    chk("exact_runs", runs,      6);
    chk("exact_q",    quotient,  33);
    chk("exact_r",    remainder, 0);
    @(negedge clk);
    chk("exact_done_1cyc", done, 0);

    // with remainder
    do_op(12'd1028, 6'd33);
    chk("rem_lat", lat,         6);
    chk("rem_q",   quotient,    31);
    chk("rem_r",   remainder,   5);
    chk("rem_dz",  div_by_zero, 0);
    chk("rem_ov",  overflow,    0);
    @(negedge clk);

    // max valid then overflow
    do_op(12'd3969, 6'd63);
    chk("max_q", quotient,  63);
    chk("max_r", remainder, 0);
    @(negedge clk);
    do_op(12'd4032, 6'd63);
    chk("ov_lat",  lat,         1);
    chk("ov_runs", runs,        0);
    chk("ov_flag", overflow,    1);
    chk("ov_dz",   div_by_zero, 0);
    chk("ov_q",    quotient,    63);
    chk("ov_r",    remainder,   0);
    @(negedge clk);
    chk("ov_done_1cyc", done, 0);

    // divide by zero
    do_op(12'd100, 6'd0);
    chk("dz_lat",  lat,         1);
    chk("dz_runs", runs,        0);
    chk("dz_flag", div_by_zero, 1);
    chk("dz_ov",   overflow,    0);
    chk("dz_q",    quotient,    63);
    chk("dz_r",    remainder,   0);
    @(negedge clk);

    // valid op clears flags; previous result held mid-op
    dividend = 12'd1089;
    divisor  = 6'd33;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("hold_q",   quotient,    63);
    chk("hold_dz",  div_by_zero, 1);
    chk("hold_run", run,         1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q",   quotient,    0);
    chk("mid_rst_r",   remainder,   0);
    chk("mid_rst_run", run,         0);
    chk("mid_rst_dz",  div_by_zero, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 1) rst_n = 1'b1;
    end
    chk("mid_rst_no_done", dones, 0);
    do_op(12'd1028, 6'd33);
    chk("post_rst_q", quotient,  31);
    chk("post_rst_r", remainder, 5);
    @(negedge clk);

    // back-to-back with ignored start during DIVIDE
    dividend = 12'd1089;
    divisor  = 6'd33;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    @(negedge clk);
    @(negedge clk);
    lat      = 2;
    dividend = 12'd2113;
    divisor  = 6'd45;
    start    = 1'b1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_lat", lat,       6);
    chk("b2b_first_q",   quotient,  33);
    chk("b2b_first_r",   remainder, 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_drop", done, 0);
    chk("b2b_run_rise",  run,  1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_second_gap", lat,       7);
    chk("b2b_second_q",   quotient,  46);
    chk("b2b_second_r",   remainder, 43);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
